// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32-bit MIPS register file with two combinational read ports
// and same-cycle writeback bypass; register 0 reads as zero and has no storage.
module register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_enable_1,
    input  logic [ADDRESS_WIDTH-1:0] read_address_1,
    output logic [DATA_WIDTH-1:0]    read_data_1,
    input  logic                     read_enable_2,
    input  logic [ADDRESS_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0]    read_data_2
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_registers [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] w_stored_1;
    logic [DATA_WIDTH-1:0] w_stored_2;
    logic                  w_write_valid;

    assign w_write_valid = write_enable && (write_address != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_registers[i] <= '0;
            end
        end else if (w_write_valid) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (write_address == ADDRESS_WIDTH'(i)) begin
                    r_registers[i] <= write_data;
                end
            end
        end
    end

    // Address 0 has no entry, so it falls through to the zero default.
    always_comb begin
        w_stored_1 = '0;
        w_stored_2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (read_address_1 == ADDRESS_WIDTH'(i)) begin
                w_stored_1 = r_registers[i];
            end
            if (read_address_2 == ADDRESS_WIDTH'(i)) begin
                w_stored_2 = r_registers[i];
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] f_read_port(
        input logic                     enable,
        input logic [ADDRESS_WIDTH-1:0] address,
        input logic [DATA_WIDTH-1:0]    stored
    );
        logic [DATA_WIDTH-1:0] result;
        result = '0;
        if (reset || (address == '0) || !enable) begin
            result = '0;
        end else if (write_enable && (write_address == address)) begin
            result = write_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    always_comb begin
        read_data_1 = f_read_port(read_enable_1, read_address_1, w_stored_1);
        read_data_2 = f_read_port(read_enable_2, read_address_2, w_stored_2);
    end

endmodule
